// File: rtl/sha256_req_arbiter.sv
// sha256_req_arbiter
//   Shares one non-pipelined sha256_1024in hasher between NUM_REQ requesters
//   (e.g. PBKDF2 iteration lanes). Round-robin grant, one hash outstanding,
//   digest registered and returned only to the requester that issued it.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_data_i           NUM_REQ x 1024-bit blocks, requester k at [k*1024 +: 1024]
//   req_valid_i/ready_o  per-requester request handshake
//   resp_data_o          registered digest (shared bus)
//   resp_valid_o         one-hot digest valid to the owning requester
//   resp_ready_i         per-requester response accept (only the owner's bit is used)
//   resp_err_o           current response is a watchdog timeout
//   hash_in_*/hash_out_* handshake to the single hasher instance
//   busy_o               FSM not idle
//   grant_id_o           index of the current owner
//
// Optional feature: define SHA_ARB_TIMEOUT_EN to build a WAIT watchdog
//   (parameter TIMEOUT_CYCLES). Without it resp_err_o is tied 0 and WAIT
//   exits only on the hasher's out_valid.
module sha256_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef SHA_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ*1024-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [255:0]              resp_data_o,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic                      resp_err_o,
    output logic [1023:0]             hash_in_o,
    output logic                      hash_in_valid_o,
    input  logic                      hash_in_ready_i,
    input  logic [255:0]              hash_out_i,
    input  logic                      hash_out_valid_i,
    output logic                      hash_out_ready_o,
    output logic                      busy_o,
    output logic [ID_W-1:0]           grant_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [255:0]    resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Round-robin pick: first valid requester scanning from rr_ptr upward,
    // wrapping modulo NUM_REQ (which need not be a power of two).
    logic [ID_W-1:0] pick;
    logic            found;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;

    always_comb begin
        pick     = rr_ptr_q;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req_valid_i[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
`ifdef SHA_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    resp_err_d = 1'b0;   // a stale timeout flag clears as the next request issues
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hash_in_ready_i) begin
                    state_d = ST_WAIT;
`ifdef SHA_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (hash_out_valid_i) begin
                    resp_data_d = hash_out_i;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready_i[grant_q]) begin
                    rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
`ifdef SHA_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // Handshake outputs decode the registered state; req_ready follows the
    // hasher's in_ready so the requester sees the exact acceptance cycle.
    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        hash_in_valid_o  = 1'b0;
        hash_out_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef SHA_ARB_TIMEOUT_EN
                // drain a digest that shows up after its request timed out
                hash_out_ready_o = 1'b1;
`endif
            end
            ST_ISSUE: begin
                hash_in_valid_o       = 1'b1;
                req_ready_o[grant_q]  = hash_in_ready_i;
            end
            ST_WAIT:  hash_out_ready_o      = 1'b1;
            ST_RESP:  resp_valid_o[grant_q] = 1'b1;
            default: ;
        endcase
    end

    assign hash_in_o   = req_data_i[grant_q*1024 +: 1024];
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_sha256_req_arbiter.sv
module tb_sha256_req_arbiter;
    localparam int N = 4;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam logic EXP_IDLE_ORDY = 1'b1;
`else
    localparam logic EXP_IDLE_ORDY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*1024-1:0] req_data_i = '0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [255:0]      resp_data_o;
    logic [N-1:0]      resp_valid_o;
    logic [N-1:0]      resp_ready_i = '0;
    logic              resp_err_o;
    logic [1023:0]     hash_in_o;
    logic              hash_in_valid_o;
    logic              hash_in_ready_i;
    logic [255:0]      hash_out_i;
    logic              hash_out_valid_i;
    logic              hash_out_ready_o;
    logic              busy_o;
    logic [1:0]        grant_id_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    sha256_req_arbiter #(
        .NUM_REQ(N),
        .ID_W(2)
`ifdef SHA_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_err_o(resp_err_o),
        .hash_in_o(hash_in_o), .hash_in_valid_o(hash_in_valid_o), .hash_in_ready_i(hash_in_ready_i),
        .hash_out_i(hash_out_i), .hash_out_valid_i(hash_out_valid_i), .hash_out_ready_o(hash_out_ready_o),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    // Hasher stub: returns hash_in[255:0] 8 cycles after acceptance.
    logic         stub_busy;
    int           stub_cnt;
    logic [255:0] stub_dig;
    logic         stub_hold_rdy = 1'b0;
    logic         stub_never = 1'b0;
    int           stub_issues = 0;

    assign hash_in_ready_i  = !stub_busy && !stub_hold_rdy;
    assign hash_out_valid_i = stub_busy && (stub_cnt == 0) && !stub_never;
    assign hash_out_i       = stub_dig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            stub_dig  <= '0;
        end else if (!stub_busy) begin
            if (hash_in_valid_o && hash_in_ready_i) begin
                stub_busy   <= 1'b1;
                stub_cnt    <= 7;
                stub_dig    <= hash_in_o[255:0];
                stub_issues <= stub_issues + 1;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end else if (hash_out_valid_i && hash_out_ready_o) begin
            stub_busy <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] mk(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(k);
        return {8{w}};
    endfunction

    task automatic set_blk(input int k, input logic [255:0] v);
        req_data_i[k*1024 +: 256] = v;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid_i = '0; resp_ready_i = '0;
        stub_hold_rdy = 1'b0; stub_never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait for a response, then handshake it for the owner.
    task automatic serve(input logic drop, output logic ok, output int gid,
                         output logic [255:0] dig, output logic err, output logic [N-1:0] rv);
        int n;
        n = 0; ok = 1'b0; gid = -1; dig = '0; err = 1'b0; rv = '0;
        while (resp_valid_o == '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid_o == '0) return;
        ok = 1'b1; rv = resp_valid_o; dig = resp_data_o; err = resp_err_o;
        for (int k = 0; k < N; k++) if (rv[k] && gid < 0) gid = k;
        resp_ready_i = rv;
        if (drop) req_valid_i = req_valid_i & ~rv;
        @(negedge clk);
        resp_ready_i = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy_o); else pass_cnt++;
        chk_cnt++; if (grant_id_o !== 2'd0) $display("FAIL reset_grant got=%0d exp=0", grant_id_o); else pass_cnt++;
        chk_cnt++; if (resp_data_o !== 256'd0) $display("FAIL reset_data got=%h exp=0", resp_data_o); else pass_cnt++;
        chk_cnt++; if (resp_err_o !== 1'b0) $display("FAIL reset_err got=%0b exp=0", resp_err_o); else pass_cnt++;
        chk_cnt++; if ({req_ready_o, resp_valid_o, hash_in_valid_o} !== 9'd0)
            $display("FAIL reset_valids got=%b exp=0", {req_ready_o, resp_valid_o, hash_in_valid_o}); else pass_cnt++;
        chk_cnt++; if (hash_out_ready_o !== EXP_IDLE_ORDY)
            $display("FAIL reset_out_ready got=%0b exp=%0b", hash_out_ready_o, EXP_IDLE_ORDY); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [255:0] v, dig;
        logic ok, err;
        int gid;
        logic [N-1:0] rv;
        v = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
        apply_reset();
        set_blk(2, v);
        req_valid_i = 4'b0100;
        @(negedge clk);
        chk_cnt++; if (grant_id_o !== 2'd2) $display("FAIL single_grant got=%0d exp=2", grant_id_o); else pass_cnt++;
        chk_cnt++; if (hash_in_valid_o !== 1'b1) $display("FAIL single_in_valid got=%0b exp=1", hash_in_valid_o); else pass_cnt++;
        chk_cnt++; if (hash_in_o[255:0] !== v) $display("FAIL single_hash_in got=%h exp=%h", hash_in_o[255:0], v); else pass_cnt++;
        chk_cnt++; if (req_ready_o !== 4'b0100) $display("FAIL single_req_ready got=%b exp=0100", req_ready_o); else pass_cnt++;
        @(negedge clk);
        req_valid_i = '0;
        chk_cnt++; if ({busy_o, hash_out_ready_o, hash_in_valid_o} !== 3'b110)
            $display("FAIL single_wait got=%b exp=110", {busy_o, hash_out_ready_o, hash_in_valid_o}); else pass_cnt++;
        serve(1'b0, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || rv !== 4'b0100) $display("FAIL single_resp_valid got=%b exp=0100", rv); else pass_cnt++;
        chk_cnt++; if (dig !== v) $display("FAIL single_resp_data got=%h exp=%h", dig, v); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL single_resp_err got=%0b exp=0", err); else pass_cnt++;
        // rr_ptr now 3: with requesters 0 and 3 both valid, 3 must win first
        set_blk(0, mk(0)); set_blk(3, mk(3));
        req_valid_i = 4'b1001;
        @(negedge clk);
        chk_cnt++; if (grant_id_o !== 2'd3) $display("FAIL single_rr_ptr got=%0d exp=3", grant_id_o); else pass_cnt++;
        serve(1'b1, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 3 || dig !== mk(3)) $display("FAIL single_next3 got=%0d/%h exp=3/%h", gid, dig, mk(3)); else pass_cnt++;
        serve(1'b1, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 0 || dig !== mk(0)) $display("FAIL single_next0 got=%0d/%h exp=0/%h", gid, dig, mk(0)); else pass_cnt++;
    endtask

    task automatic test_rr_order();
        logic [255:0] dig;
        logic ok, err;
        int gid;
        logic [N-1:0] rv;
        apply_reset();
        for (int k = 0; k < N; k++) set_blk(k, mk(k));
        req_valid_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1'b0, ok, gid, dig, err, rv);
            chk_cnt++; if (!ok || gid != (i % 4)) $display("FAIL rr_order_%0d got=%0d exp=%0d", i, gid, i % 4); else pass_cnt++;
            chk_cnt++; if (rv !== (4'b0001 << (i % 4))) $display("FAIL rr_onehot_%0d got=%b exp=%b", i, rv, 4'b0001 << (i % 4)); else pass_cnt++;
            chk_cnt++; if (dig !== mk(i % 4)) $display("FAIL rr_data_%0d got=%h exp=%h", i, dig, mk(i % 4)); else pass_cnt++;
        end
        req_valid_i = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n, issued, gid;
        logic [255:0] dig;
        logic ok, err;
        logic [N-1:0] rv;
        apply_reset();
        set_blk(1, mk(1)); set_blk(0, mk(10));
        req_valid_i = 4'b0010;
        n = 0;
        while (resp_valid_o == '0 && n < 80) begin @(negedge clk); n++; end
        chk_cnt++; if (resp_valid_o !== 4'b0010) $display("FAIL bp_first_resp got=%b exp=0010", resp_valid_o); else pass_cnt++;
        req_valid_i = 4'b0001;
        issued = stub_issues;
        repeat (20) begin
            @(negedge clk);
            chk_cnt++; if (resp_valid_o !== 4'b0010) $display("FAIL bp_hold_valid got=%b exp=0010", resp_valid_o); else pass_cnt++;
            chk_cnt++; if (resp_data_o !== mk(1)) $display("FAIL bp_hold_data got=%h exp=%h", resp_data_o, mk(1)); else pass_cnt++;
            chk_cnt++; if (hash_in_valid_o !== 1'b0) $display("FAIL bp_no_issue got=%0b exp=0", hash_in_valid_o); else pass_cnt++;
        end
        // a non-owner's ready must be ignored
        resp_ready_i = 4'b0001;
        @(negedge clk);
        chk_cnt++; if (resp_valid_o !== 4'b0010) $display("FAIL bp_nonowner_ready got=%b exp=0010", resp_valid_o); else pass_cnt++;
        chk_cnt++; if (stub_issues != issued) $display("FAIL bp_stub_issues got=%0d exp=%0d", stub_issues, issued); else pass_cnt++;
        resp_ready_i = 4'b0010;
        @(negedge clk);
        resp_ready_i = '0;
        chk_cnt++; if ({busy_o, resp_valid_o} !== 5'd0) $display("FAIL bp_release got=%b exp=0", {busy_o, resp_valid_o}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (grant_id_o !== 2'd0 || hash_in_valid_o !== 1'b1)
            $display("FAIL bp_next_grant got=%0d/%0b exp=0/1", grant_id_o, hash_in_valid_o); else pass_cnt++;
        serve(1'b1, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 0 || dig !== mk(10)) $display("FAIL bp_next_resp got=%0d/%h exp=0/%h", gid, dig, mk(10)); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        int n, gid;
        logic [255:0] dig;
        logic ok, err;
        logic [N-1:0] rv;
        set_blk(1, mk(5));
        req_valid_i = 4'b0010;
        n = 0;
        while (!(busy_o && hash_out_ready_o) && n < 20) begin @(negedge clk); n++; end
        chk_cnt++; if (!(busy_o && hash_out_ready_o)) $display("FAIL rw_reach_wait got=%0b exp=1", busy_o && hash_out_ready_o); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req_valid_i = '0;
        #1;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL rw_busy got=%0b exp=0", busy_o); else pass_cnt++;
        chk_cnt++; if (grant_id_o !== 2'd0) $display("FAIL rw_grant got=%0d exp=0", grant_id_o); else pass_cnt++;
        chk_cnt++; if (resp_data_o !== 256'd0) $display("FAIL rw_data got=%h exp=0", resp_data_o); else pass_cnt++;
        chk_cnt++; if ({req_ready_o, resp_valid_o, hash_in_valid_o, resp_err_o} !== 10'd0)
            $display("FAIL rw_outputs got=%b exp=0", {req_ready_o, resp_valid_o, hash_in_valid_o, resp_err_o}); else pass_cnt++;
        chk_cnt++; if (hash_out_ready_o !== EXP_IDLE_ORDY) $display("FAIL rw_out_ready got=%0b exp=%0b", hash_out_ready_o, EXP_IDLE_ORDY); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid_i = 4'b0010;
        serve(1'b1, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 1 || dig !== mk(5)) $display("FAIL rw_replay got=%0d/%h exp=1/%h", gid, dig, mk(5)); else pass_cnt++;
    endtask

    task automatic test_in_ready_stall();
        int base, gid;
        logic [255:0] dig;
        logic ok, err;
        logic [N-1:0] rv;
        apply_reset();
        stub_hold_rdy = 1'b1;
        base = stub_issues;
        set_blk(3, mk(3));
        req_valid_i = 4'b1000;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL stall_ready_c%0d got=%b exp=0000", c, req_ready_o); else pass_cnt++;
            chk_cnt++; if (hash_in_valid_o !== 1'b1 || grant_id_o !== 2'd3)
                $display("FAIL stall_issue_c%0d got=%0b/%0d exp=1/3", c, hash_in_valid_o, grant_id_o); else pass_cnt++;
            @(negedge clk);
        end
        stub_hold_rdy = 1'b0;
        #1;
        chk_cnt++; if (req_ready_o !== 4'b1000) $display("FAIL stall_accept got=%b exp=1000", req_ready_o); else pass_cnt++;
        @(negedge clk);
        req_valid_i = '0;
        chk_cnt++; if (hash_in_valid_o !== 1'b0 || hash_out_ready_o !== 1'b1)
            $display("FAIL stall_wait got=%0b/%0b exp=0/1", hash_in_valid_o, hash_out_ready_o); else pass_cnt++;
        serve(1'b0, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 3 || dig !== mk(3)) $display("FAIL stall_resp got=%0d/%h exp=3/%h", gid, dig, mk(3)); else pass_cnt++;
        chk_cnt++; if (stub_issues != base + 1) $display("FAIL stall_single_issue got=%0d exp=%0d", stub_issues - base, 1); else pass_cnt++;
    endtask

`ifdef SHA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n, gid;
        logic [255:0] dig;
        logic ok, err;
        logic [N-1:0] rv;
        stub_never = 1'b1;
        set_blk(0, mk(7));
        req_valid_i = 4'b0001;
        n = 0;
        while (!(busy_o && hash_out_ready_o) && n < 20) begin @(negedge clk); n++; end
        chk_cnt++; if (!(busy_o && hash_out_ready_o)) $display("FAIL tmo_reach_wait got=%0b exp=1", busy_o && hash_out_ready_o); else pass_cnt++;
        req_valid_i = '0;
        repeat (15) @(negedge clk);
        chk_cnt++; if (resp_valid_o !== 4'b0000) $display("FAIL tmo_early got=%b exp=0000", resp_valid_o); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (resp_valid_o !== 4'b0001) $display("FAIL tmo_valid got=%b exp=0001", resp_valid_o); else pass_cnt++;
        chk_cnt++; if (resp_err_o !== 1'b1) $display("FAIL tmo_err got=%0b exp=1", resp_err_o); else pass_cnt++;
        chk_cnt++; if (resp_data_o !== 256'd0) $display("FAIL tmo_data got=%h exp=0", resp_data_o); else pass_cnt++;
        resp_ready_i = 4'b0001;
        stub_never = 1'b0;      // late digest now appears and must be drained in IDLE
        @(negedge clk);
        resp_ready_i = '0;
        chk_cnt++; if (busy_o !== 1'b0 || resp_err_o !== 1'b1) $display("FAIL tmo_idle got=%0b/%0b exp=0/1", busy_o, resp_err_o); else pass_cnt++;
        set_blk(1, mk(8));
        req_valid_i = 4'b0010;
        @(negedge clk);
        chk_cnt++; if (resp_err_o !== 1'b0 || req_ready_o !== 4'b0010)
            $display("FAIL tmo_err_clear got=%0b/%b exp=0/0010", resp_err_o, req_ready_o); else pass_cnt++;
        @(negedge clk);
        req_valid_i = '0;
        serve(1'b0, ok, gid, dig, err, rv);
        chk_cnt++; if (!ok || gid != 1 || dig !== mk(8) || err !== 1'b0)
            $display("FAIL tmo_after got=%0d/%h/%0b exp=1/%h/0", gid, dig, err, mk(8)); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_backpressure();
        test_reset_in_wait();
        test_in_ready_stall();
`ifdef SHA_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
